// File: rtl/amber128_reset_seq.sv
// amber128_reset_seq: board reset synchroniser, hold stretcher and
// staged per-channel reset release for one clock domain.
module amber128_reset_seq #(
    parameter int STAGES      = 2,
    parameter int NCH         = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           sw_req_i,
    output logic [NCH-1:0] rst_no,
    output logic           busy_o,
    output logic           done_o,
    output logic [1:0]     cause_o
);

    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NCH + 1);

    localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_INIT  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NCH - 1);

    localparam logic [1:0] CAUSE_HARD = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;

    generate
        if (STAGES < 2) begin : g_bad_stages
            $fatal(1, "amber128_reset_seq: STAGES must be >= 2");
        end
        if (NCH < 1) begin : g_bad_nch
            $fatal(1, "amber128_reset_seq: NCH must be >= 1");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $fatal(1, "amber128_reset_seq: HOLD_CYCLES must be >= 1");
        end
        if (GAP_CYCLES < 1) begin : g_bad_gap
            $fatal(1, "amber128_reset_seq: GAP_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_RESET,
        S_SYNC,
        S_HOLD,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t            state_q, state_d;
    logic [STAGES-1:0] sync_ff_q, sync_ff_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NCH-1:0]    rst_n_q, rst_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        cause_q, cause_d;
    logic              soft_ok;

    // Next-state and next-output computation; soft request overrides all.
    always_comb begin
        state_d   = state_q;
        sync_ff_d = sync_ff_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_n_d   = rst_n_q;
        busy_d    = busy_q;
        done_d    = done_q;
        cause_d   = cause_q;
        soft_ok   = 1'b0;

        unique case (state_q)
            S_RESET, S_SYNC: begin
                sync_ff_d = {sync_ff_q[STAGES-2:0], 1'b1};
                if (sync_ff_q[STAGES-1]) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_INIT;
                end else begin
                    state_d = S_SYNC;
                end
            end
            S_HOLD: begin
                soft_ok = 1'b1;
                if (cnt_q == '0) begin
                    rst_n_d[0] = 1'b1;
                    idx_d      = IDX_ONE;
                    cnt_d      = GAP_INIT;
                    if (NCH == 1) begin
                        state_d = S_RUN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RELEASE: begin
                soft_ok = 1'b1;
                if (cnt_q == '0) begin
                    for (int k = 0; k < NCH; k++) begin
                        if (idx_q == IW'(k)) begin
                            rst_n_d[k] = 1'b1;
                        end
                    end
                    idx_d = idx_q + IDX_ONE;
                    cnt_d = GAP_INIT;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_RUN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RUN: begin
                soft_ok = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase

        if (soft_ok && sw_req_i) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_INIT;
            idx_d   = '0;
            rst_n_d = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            cause_d = CAUSE_SOFT;
        end
    end

    // Sequencer state and registered outputs; rst_i forces reset asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_RESET;
            sync_ff_q <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_n_q   <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            cause_q   <= CAUSE_HARD;
        end else begin
            state_q   <= state_d;
            sync_ff_q <= sync_ff_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_n_q   <= rst_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cause_q   <= cause_d;
        end
    end

    assign rst_no  = rst_n_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign cause_o = cause_q;

endmodule

// File: tb/tb_amber128_reset_seq.sv
// tb_amber128_reset_seq: directed checks of power-on, soft, held,
// coincident, mid-sequence and asynchronous reset behaviour.
module tb_amber128_reset_seq;

    logic       clk    = 1'b0;
    logic       clk_en = 1'b1;
    logic       rst    = 1'b1;
    logic       rst2   = 1'b1;
    logic       sw     = 1'b0;
    logic [3:0] rst_no;
    logic       busy, done;
    logic [1:0] cause;
    logic [0:0] rst_no2;
    logic       busy2, done2;
    logic [1:0] cause2;

    int checks = 0;
    int errors = 0;

    always #5 clk = clk_en ? ~clk : 1'b0;

    amber128_reset_seq u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .sw_req_i(sw),
        .rst_no  (rst_no),
        .busy_o  (busy),
        .done_o  (done),
        .cause_o (cause)
    );

    amber128_reset_seq #(
        .STAGES     (3),
        .NCH        (1),
        .HOLD_CYCLES(1),
        .GAP_CYCLES (1)
    ) u_dut2 (
        .clk_i   (clk),
        .rst_i   (rst2),
        .sw_req_i(1'b0),
        .rst_no  (rst_no2),
        .busy_o  (busy2),
        .done_o  (done2),
        .cause_o (cause2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rst(input string tag, input logic [1:0] c);
        chk({tag, "_rstno"}, 32'(rst_no), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(1));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_cause"}, 32'(cause), 32'(c));
    endtask

    // Edge e counts from the first rising edge after rst falls.
    task automatic por_run(input int n, input bit two);
        logic [3:0] er;
        for (int e = 1; e <= n; e++) begin
            step();
            for (int k = 0; k < 4; k++) er[k] = (e >= 19 + 4 * k);
            chk($sformatf("por%0d_rstno", e), 32'(rst_no), 32'(er));
            chk($sformatf("por%0d_done", e), 32'(done), 32'(e >= 31));
            chk($sformatf("por%0d_busy", e), 32'(busy), 32'(e < 31));
            if (two && e <= 6) begin
                chk($sformatf("swp%0d_rstno", e), 32'(rst_no2), 32'(e >= 5));
                chk($sformatf("swp%0d_done", e), 32'(done2), 32'(e >= 5));
                chk($sformatf("swp%0d_busy", e), 32'(busy2), 32'(e < 5));
            end
        end
        chk("por_cause", 32'(cause), 32'(2'b01));
    endtask

    // Edge j counts from the last edge that sampled sw_req_i high.
    task automatic soft_run(input int n);
        logic [3:0] er;
        for (int j = 1; j <= n; j++) begin
            step();
            for (int k = 0; k < 4; k++) er[k] = (j >= 16 + 4 * k);
            chk($sformatf("sw%0d_rstno", j), 32'(rst_no), 32'(er));
            chk($sformatf("sw%0d_done", j), 32'(done), 32'(j >= 28));
            chk($sformatf("sw%0d_busy", j), 32'(busy), 32'(j < 28));
            chk($sformatf("sw%0d_cause", j), 32'(cause), 32'(2'b10));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // power-on with defaults and the small-parameter instance
        repeat (5) begin
            step();
            chk_rst("por_rst", 2'b01);
            chk("swp_rst_rstno", 32'(rst_no2), 32'(0));
            chk("swp_rst_busy", 32'(busy2), 32'(1));
            chk("swp_rst_cause", 32'(cause2), 32'(2'b01));
        end
        rst  = 1'b0;
        rst2 = 1'b0;
        por_run(32, 1'b1);

        // single-cycle soft request from RUN
        sw = 1'b1;
        step();
        sw = 1'b0;
        chk_rst("soft", 2'b10);
        soft_run(29);

        // request held for 10 cycles during RELEASE
        sw = 1'b1;
        step();
        sw = 1'b0;
        soft_run(17);
        sw = 1'b1;
        repeat (10) begin
            step();
            chk_rst("held", 2'b10);
        end
        sw = 1'b0;
        soft_run(29);

        // request on the exact edge that would release channel 1
        sw = 1'b1;
        step();
        sw = 1'b0;
        soft_run(19);
        sw = 1'b1;
        step();
        sw = 1'b0;
        chk_rst("coinc", 2'b10);
        soft_run(29);

        // hard reset mid-hold at count 7 after a soft request
        sw = 1'b1;
        step();
        sw = 1'b0;
        soft_run(8);
        #2 rst = 1'b1;
        #1 chk_rst("midhard", 2'b01);
        step();
        step();
        chk_rst("midhard_held", 2'b01);
        rst = 1'b0;
        por_run(32, 1'b0);

        // asynchronous assertion between edges with the clock running
        #2 rst = 1'b1;
        #1 chk_rst("async", 2'b01);
        step();
        rst = 1'b0;
        por_run(32, 1'b0);

        // asynchronous assertion with the clock stopped
        clk_en = 1'b0;
        #30;
        rst  = 1'b1;
        rst2 = 1'b1;
        #1;
        chk_rst("stopped", 2'b01);
        chk("stopped2_rstno", 32'(rst_no2), 32'(0));
        chk("stopped2_done", 32'(done2), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/amber128_reset_seq.md
# amber128_reset_seq

Parametrised reset sequencer: asynchronously asserts a bank of active-low reset outputs, synchronises the release of the board reset into `clk_i`, and stretches the asserted period by a programmable hold time. It then releases the channels one at a time in index order, with a fixed gap between releases. A synchronous software reset request re-runs the hold/release sequence without the synchroniser. It sits between the platform reset input and the per-subsystem reset nets of one clock domain.

## Interface
- `STAGES`, default 2: synchroniser depth. Must be >= 2; elaboration is fatal otherwise.
- `NCH`, default 4: number of reset channels. Must be >= 1.
- `HOLD_CYCLES`, default 16: cycles all channels stay asserted after sync completes or after a soft request. Must be >= 1.
- `GAP_CYCLES`, default 4: cycles between consecutive channel releases. Must be >= 1.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `sw_req_i`  in  1  synchronous soft-reset request, sampled on `clk_i`.
- `rst_no`  out  NCH  per-channel reset, active-low (0 = channel held in reset).
- `busy_o`  out  1  sequence in progress.
- `done_o`  out  1  all channels released.
- `cause_o`  out  2  source of the last sequence: 2'b01 = hard (`rst_i`), 2'b10 = soft (`sw_req_i`).

## Operation
- FSM states: RESET, SYNC, HOLD, RELEASE, RUN.
- Internal regs:
  - `sync_ff[STAGES-1:0]`
  - down-counter `cnt`, width $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1)
  - channel index `idx`, width $clog2(NCH+1)
- **`rst_i` high (async, any state):**
  - `sync_ff`=0, state=RESET, `cnt`=0, `idx`=0.
  - `rst_no`=0, `busy_o`=1, `done_o`=0, `cause_o`=2'b01.
- **RESET/SYNC:**
  - `sync_ff` shifts in 1 each edge.
  - State is SYNC until `sync_ff[STAGES-1]`=1.
  - On the first edge where `sync_ff[STAGES-1]`=1: state=HOLD, `cnt`=HOLD_CYCLES-1.
  - `sw_req_i` is ignored in RESET and SYNC.
- **HOLD:**
  - `cnt` decrements each edge.
  - At the edge where `cnt`==0: `rst_no[0]`=1, `idx`=1, `cnt`=GAP_CYCLES-1.
  - Next state is RELEASE, or RUN if NCH==1.
- **RELEASE:**
  - `cnt` decrements each edge.
  - At the edge where `cnt`==0: `rst_no[idx]`=1, `idx`++, `cnt`=GAP_CYCLES-1.
  - When `idx`==NCH-1 is released: state=RUN.
- **RUN:** `busy_o`=0, `done_o`=1, all `rst_no`=1.
- **Soft request:** `sw_req_i`=1 sampled in HOLD, RELEASE or RUN. At that edge:
  - all `rst_no`=0, `done_o`=0, `busy_o`=1, `cause_o`=2'b10.
  - state=HOLD, `cnt`=HOLD_CYCLES-1, `idx`=0.
  - Restarts the hold even if already in HOLD. Held high, it keeps re-entering HOLD.
- Release is monotonic. Once released, a channel is re-asserted only by `rst_i` or a soft request. A channel never releases before a lower index.
- `rst_no` channel bits are driven only by release events, the soft request and `rst_i`. No other path clears a released channel.

## Timing
- Edge numbering: edge 1 is the first `clk_i` rising edge with `rst_i` low.
- `sync_ff[STAGES-1]` goes 1 at edge STAGES.
- `rst_no[k]` rises at edge STAGES+HOLD_CYCLES+1+k*GAP_CYCLES.
- `done_o` rises and `busy_o` falls at the same edge as `rst_no[NCH-1]`.
- Defaults: channels release at edges 19/23/27/31; `done_o` at 31.
- Soft request sampled at edge R:
  - all `rst_no` low after R.
  - `rst_no[k]` rises at edge R+HOLD_CYCLES+k*GAP_CYCLES.
  - Defaults: 16/20/24/28 edges after R.
- Assertion of `rst_i` reaches all outputs asynchronously, with no clock required.
- All deassertions and all soft-request effects are registered on `clk_i`.
- Only `rst_i` has a combinational path from input to output.
- `rst_i` reasserted mid-sequence aborts immediately; the full sequence including SYNC restarts after release.
- `sw_req_i` coincident with a release edge: the soft request wins and no channel releases.

## Test plan
- **Power-on, defaults:** `rst_i`=1 for 5 cycles, then 0.
  - `rst_no`=4'b0000, `busy_o`=1, `cause_o`=01 during reset.
  - Bits set at edges 19/23/27/31; `done_o`=1 at 31.
- **Async assertion:** in RUN, raise `rst_i` between clock edges.
  - `rst_no`=0, `done_o`=0 before the next edge.
  - With the clock stopped, outputs still assert.
- **Soft reset:** in RUN, pulse `sw_req_i` for 1 cycle at edge R.
  - `rst_no`=0 after R; releases at R+16/R+20/R+24/R+28.
  - `cause_o`=10; no SYNC delay.
- **Held and coincident requests:** hold `sw_req_i` high for 10 cycles during RELEASE, then drop it (last sampled at R).
  - Outputs stay 0; releases timed from R.
  - A request on the exact edge of `rst_no[1]` release gives `rst_no[1]`=0.
- **Mid-sequence hard reset:** assert `rst_i` during HOLD at count 7.
  - All outputs back to reset values.
  - After release, ch0 rises at edge 19 again.
- **Parameter sweep:** STAGES=3, NCH=1, HOLD_CYCLES=1, GAP_CYCLES=1.
  - `rst_no[0]` and `done_o` rise at edge 5.
  - STAGES=1 fails elaboration.
